// File: rtl/perceptron_frame_loader.sv
// Byte-serial frame loader for the perceptron core: hunts for sync, shadows x/w/bias,
// commits on a good XOR checksum, pulses start, then waits for the core to go idle.
module perceptron_frame_loader #(
    parameter int unsigned N_INPUTS  = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [8*N_INPUTS-1:0] vec_x,
    output logic [8*N_INPUTS-1:0] vec_w,
    output logic [7:0]            bias,
    output logic                  start,
    input  logic                  core_busy,
    output logic                  frame_err,
    output logic [7:0]            frame_cnt
);

    localparam int unsigned IdxW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int unsigned VecW = 8 * N_INPUTS;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(N_INPUTS - 1);

    typedef enum logic [2:0] {
        StHunt,
        StLoadX,
        StLoadW,
        StLoadB,
        StCheck,
        StFire,
        StWaitCore
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [7:0]        chk_q, chk_d;
    logic [VecW-1:0]   shx_q, shx_d, shw_q, shw_d;
    logic [7:0]        shb_q, shb_d;
    logic [VecW-1:0]   vx_q, vx_d, vw_q, vw_d;
    logic [7:0]        b_q, b_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              first_q, first_d;
    logic              xfer;

    // Ready depends on state only; gated low while reset is held.
    assign in_ready = ~rst && (state_q != StFire) && (state_q != StWaitCore);
    assign xfer     = in_valid && in_ready;

    assign vec_x     = vx_q;
    assign vec_w     = vw_q;
    assign bias      = b_q;
    assign frame_err = err_q;
    assign frame_cnt = cnt_q;
    assign start     = (state_q == StFire);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        chk_d   = chk_q;
        shx_d   = shx_q;
        shw_d   = shw_q;
        shb_d   = shb_q;
        vx_d    = vx_q;
        vw_d    = vw_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        first_d = first_q;
        unique case (state_q)
            StHunt: begin
                if (xfer && (in_data == SYNC_BYTE)) begin
                    state_d = StLoadX;
                    idx_d   = '0;
                    chk_d   = 8'h00;
                end
            end
            StLoadX: begin
                if (xfer) begin
                    shx_d[8*idx_q +: 8] = in_data;
                    chk_d = chk_q ^ in_data;
                    if (idx_q == IdxLast) begin
                        state_d = StLoadW;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StLoadW: begin
                if (xfer) begin
                    shw_d[8*idx_q +: 8] = in_data;
                    chk_d = chk_q ^ in_data;
                    if (idx_q == IdxLast) begin
                        state_d = StLoadB;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StLoadB: begin
                if (xfer) begin
                    shb_d   = in_data;
                    chk_d   = chk_q ^ in_data;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (xfer) begin
                    if (in_data == chk_q) begin
                        vx_d    = shx_q;
                        vw_d    = shw_q;
                        b_d     = shb_q;
                        cnt_d   = cnt_q + 8'd1;
                        state_d = StFire;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StHunt;
                    end
                end
            end
            StFire: begin
                first_d = 1'b1;
                state_d = StWaitCore;
            end
            StWaitCore: begin
                // The first cycle is always held so a core that raises busy late is seen.
                if (first_q) begin
                    first_d = 1'b0;
                end else if (!core_busy) begin
                    state_d = StHunt;
                end
            end
            default: state_d = StHunt;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StHunt;
            idx_q   <= '0;
            chk_q   <= 8'h00;
            shx_q   <= '0;
            shw_q   <= '0;
            shb_q   <= 8'h00;
            vx_q    <= '0;
            vw_q    <= '0;
            b_q     <= 8'h00;
            cnt_q   <= 8'h00;
            err_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            chk_q   <= chk_d;
            shx_q   <= shx_d;
            shw_q   <= shw_d;
            shb_q   <= shb_d;
            vx_q    <= vx_d;
            vw_q    <= vw_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

endmodule
